reaction_timer_multi: RTL and testbench

- Parametrised multi-player successor to the single-player reaction timer.
- Flow per round: arm the round, show a "wait" message over the LCD handshake, hold a random delay, light the LEDs, then timestamp each player's first press.
- Flags cheaters (press before the LEDs light) and slow players (no press before the limit), picks the winner, and publishes the results over the same LCDUpdate/LCDAck handshake.

---
 rtl/reaction_timer_pkg.sv | 39 +++
 rtl/reaction_timer_multi_lane.sv | 89 ++++++++
 rtl/reaction_timer_multi.sv | 226 ++++++++++++++++++++++
 tb/tb_reaction_timer_multi.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reaction_timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reaction_timer_pkg
//  Description : Shared types for the multi-player reaction timer: FSM state
//                encoding, per-lane status encoding and a helper that sizes
//                the winner index.
//  Revision    : 1.0 - initial release
// ============================================================================
package reaction_timer_pkg;

   // Round sequencing states.
   typedef enum logic [2:0] {
      ST_IDLE        = 3'd0,
      ST_WAIT_MSG    = 3'd1,
      ST_RANDOM_WAIT = 3'd2,
      ST_MEASURE     = 3'd3,
      ST_RESULT_MSG  = 3'd4,
      ST_END_WAIT    = 3'd5
   } state_e;

   // Per-lane progress within one round. ACTIVE is zero so reset leaves
   // every lane without a cheat or slow flag.
   typedef enum logic [1:0] {
      LANE_ACTIVE = 2'd0,
      LANE_DONE   = 2'd1,
      LANE_CHEAT  = 2'd2,
      LANE_SLOW   = 2'd3
   } lane_status_e;

   // Width of the external Winner port.
   localparam int c_winner_w = 3;

   // Bits needed to index a player; a single player still needs one bit.
   function automatic int winner_idx_w(input int num_players);
      return (num_players > 1) ? $clog2(num_players) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/reaction_timer_multi_lane.sv
`default_nettype none
// ============================================================================
//  Module      : reaction_lane
//  Description : One player lane: rising-edge press detector, round status
//                register and reaction-time latch, steered by phase strobes
//                from the round FSM. Next-state views are exported so the
//                top can decide transitions and the winner in the same cycle
//                the lane settles.
//  Revision    : 1.0 - initial release
// ============================================================================
module reaction_lane
   import reaction_timer_pkg::*;
#(
   parameter int TIME_W     = 10,
   parameter int SLOW_LIMIT = 1000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_start,
   input  logic              i_clear,
   input  logic              i_cheat_win,
   input  logic              i_measure,
   input  logic              i_slow_strike,
   input  logic [TIME_W-1:0] i_meas_cnt,
   output logic              o_press,
   output logic              o_cheat,
   output logic              o_slow,
   output logic [TIME_W-1:0] o_time,
   output logic              o_cheat_nx,
   output logic              o_settled_nx,
   output logic              o_done_nx,
   output logic [TIME_W-1:0] o_time_nx
);

   localparam logic [TIME_W-1:0] c_slow_time = TIME_W'(SLOW_LIMIT);

   logic              start_q, start_d;
   lane_status_e      status_q, status_d;
   logic [TIME_W-1:0] time_q, time_d;
   logic              press;

   // Next-state: clear opens a fresh round; only an ACTIVE lane can settle,
   // and the slow strike outranks a press landing on the same cycle.
   always_comb begin
      start_d  = i_start;
      press    = i_start & ~start_q;
      status_d = status_q;
      time_d   = time_q;
      if (i_clear) begin
         status_d = LANE_ACTIVE;
         time_d   = '0;
      end else if (status_q == LANE_ACTIVE) begin
         if (i_slow_strike) begin
            status_d = LANE_SLOW;
            time_d   = c_slow_time;
         end else if (i_cheat_win && press) begin
            status_d = LANE_CHEAT;
            time_d   = '0;
         end else if (i_measure && press) begin
            status_d = LANE_DONE;
            time_d   = i_meas_cnt;
         end
      end
   end

   // Lane state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         start_q  <= 1'b0;
         status_q <= LANE_ACTIVE;
         time_q   <= '0;
      end else begin
         start_q  <= start_d;
         status_q <= status_d;
         time_q   <= time_d;
      end
   end

   assign o_press      = press;
   assign o_cheat      = (status_q == LANE_CHEAT);
   assign o_slow       = (status_q == LANE_SLOW);
   assign o_time       = time_q;
   assign o_cheat_nx   = (status_d == LANE_CHEAT);
   assign o_settled_nx = (status_d != LANE_ACTIVE);
   assign o_done_nx    = (status_d == LANE_DONE);
   assign o_time_nx    = time_d;

endmodule
`default_nettype wire

// File: rtl/reaction_timer_multi.sv
`default_nettype none
// ============================================================================
//  Module      : reaction_timer_multi
//  Description : Multi-player reaction timer. Arms a round on any press,
//                posts a wait message, holds a random delay, lights the LEDs
//                and timestamps each player's first press. Flags cheaters
//                and slow players, picks the winner and posts the result
//                over the LCDUpdate/LCDAck handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module reaction_timer_multi
   import reaction_timer_pkg::*;
#(
   parameter int NUM_PLAYERS = 2,
   parameter int TIME_W      = 10,
   parameter int RAND_W      = 13,
   parameter int LED_W       = 8,
   parameter int SLOW_LIMIT  = 1000,
   parameter int MIN_WAIT    = 100,
   parameter int END_WAIT    = 1000
) (
   input  logic                          Clk,
   input  logic                          Rst,
   input  logic [NUM_PLAYERS-1:0]        Start,
   input  logic [RAND_W-1:0]             RandomValue,
   input  logic                          LCDAck,
   output logic [LED_W-1:0]              LED,
   output logic [NUM_PLAYERS*TIME_W-1:0] ReactionTime,
   output logic [NUM_PLAYERS-1:0]        Cheat,
   output logic [NUM_PLAYERS-1:0]        Slow,
   output logic [c_winner_w-1:0]         Winner,
   output logic                          WinnerValid,
   output logic                          Wait,
   output logic                          LCDUpdate
);

   localparam int                IDX_W       = winner_idx_w(NUM_PLAYERS);
   localparam logic [TIME_W-1:0] c_slow_lim  = TIME_W'(SLOW_LIMIT);
   localparam logic [TIME_W-1:0] c_one_t     = TIME_W'(1);
   localparam logic [RAND_W-1:0] c_min_wait  = RAND_W'(MIN_WAIT);
   localparam logic [RAND_W-1:0] c_end_last  = RAND_W'(END_WAIT - 1);
   localparam logic [RAND_W-1:0] c_one_r     = RAND_W'(1);

   state_e                  state_q, state_d;
   logic [RAND_W-1:0]       wait_cnt_q, wait_cnt_d;
   logic [RAND_W-1:0]       wait_time_q, wait_time_d;
   logic [TIME_W-1:0]       meas_cnt_q, meas_cnt_d;
   logic [c_winner_w-1:0]   winner_q, winner_d;
   logic                    winner_valid_q, winner_valid_d;
   logic [LED_W-1:0]        led_q, led_d;
   logic                    wait_q, wait_d;
   logic                    lcd_update_q, lcd_update_d;

   // Phase strobes to the lanes.
   logic                    lane_clear;
   logic                    cheat_win;
   logic                    measure;
   logic                    slow_strike;

   // Lane views.
   logic [NUM_PLAYERS-1:0]  press;
   logic [NUM_PLAYERS-1:0]  cheat_nx;
   logic [NUM_PLAYERS-1:0]  settled_nx;
   logic [NUM_PLAYERS-1:0]  done_nx;
   logic [TIME_W-1:0]       time_nx [NUM_PLAYERS];

   // Winner search results.
   logic                    best_valid;
   logic [IDX_W-1:0]        best_idx;
   logic [TIME_W-1:0]       best_time;

   generate
      for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_lane
         reaction_lane #(
            .TIME_W     (TIME_W),
            .SLOW_LIMIT (SLOW_LIMIT)
         ) u_lane (
            .clk           (Clk),
            .rst           (Rst),
            .i_start       (Start[i]),
            .i_clear       (lane_clear),
            .i_cheat_win   (cheat_win),
            .i_measure     (measure),
            .i_slow_strike (slow_strike),
            .i_meas_cnt    (meas_cnt_q),
            .o_press       (press[i]),
            .o_cheat       (Cheat[i]),
            .o_slow        (Slow[i]),
            .o_time        (ReactionTime[i*TIME_W +: TIME_W]),
            .o_cheat_nx    (cheat_nx[i]),
            .o_settled_nx  (settled_nx[i]),
            .o_done_nx     (done_nx[i]),
            .o_time_nx     (time_nx[i])
         );
      end
   endgenerate

   // Winner: lowest time among lanes that will be DONE; strict compare in
   // ascending index order hands ties to the lowest index.
   always_comb begin
      best_valid = 1'b0;
      best_idx   = '0;
      best_time  = '0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
         if (done_nx[i] && (!best_valid || (time_nx[i] < best_time))) begin
            best_valid = 1'b1;
            best_idx   = IDX_W'(i);
            best_time  = time_nx[i];
         end
      end
   end

   // Round sequencer: next state, counters, lane strobes and result capture.
   always_comb begin
      state_d        = state_q;
      wait_cnt_d     = wait_cnt_q;
      wait_time_d    = wait_time_q;
      meas_cnt_d     = meas_cnt_q;
      winner_d       = winner_q;
      winner_valid_d = winner_valid_q;
      lane_clear     = 1'b0;
      cheat_win      = 1'b0;
      measure        = 1'b0;
      slow_strike    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (|press) begin
               state_d        = ST_WAIT_MSG;
               lane_clear     = 1'b1;
               winner_d       = '0;
               winner_valid_d = 1'b0;
            end
         end
         ST_WAIT_MSG: begin
            if (LCDAck) begin
               wait_time_d = (RandomValue < c_min_wait) ? c_min_wait : RandomValue;
               wait_cnt_d  = '0;
               state_d     = ST_RANDOM_WAIT;
            end
         end
         ST_RANDOM_WAIT: begin
            cheat_win = 1'b1;
            if (&cheat_nx) begin
               state_d = ST_RESULT_MSG;
            end else if (wait_cnt_q == (wait_time_q - c_one_r)) begin
               meas_cnt_d = '0;
               state_d    = ST_MEASURE;
            end else begin
               wait_cnt_d = wait_cnt_q + c_one_r;
            end
         end
         ST_MEASURE: begin
            measure = 1'b1;
            if (meas_cnt_q == c_slow_lim) begin
               slow_strike = 1'b1;
               state_d     = ST_RESULT_MSG;
            end else if (&settled_nx) begin
               state_d = ST_RESULT_MSG;
            end else begin
               meas_cnt_d = meas_cnt_q + c_one_t;
            end
         end
         ST_RESULT_MSG: begin
            if (LCDAck) begin
               wait_cnt_d = '0;
               state_d    = ST_END_WAIT;
            end
         end
         ST_END_WAIT: begin
            if (wait_cnt_q == c_end_last) begin
               state_d = ST_IDLE;
            end else begin
               wait_cnt_d = wait_cnt_q + c_one_r;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Winner is captured from the lanes' settling values as RESULT_MSG is
      // entered so it is valid on the first result cycle.
      if ((state_d == ST_RESULT_MSG) && (state_q != ST_RESULT_MSG)) begin
         winner_d       = c_winner_w'(best_idx);
         winner_valid_d = best_valid;
      end

      led_d        = (state_d == ST_MEASURE) ? '1 : '0;
      wait_d       = (state_d == ST_WAIT_MSG) || (state_d == ST_RANDOM_WAIT);
      lcd_update_d = (state_d == ST_WAIT_MSG) || (state_d == ST_RESULT_MSG);
   end

   // Sequencer and output registers.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q        <= ST_IDLE;
         wait_cnt_q     <= '0;
         wait_time_q    <= '0;
         meas_cnt_q     <= '0;
         winner_q       <= '0;
         winner_valid_q <= 1'b0;
         led_q          <= '0;
         wait_q         <= 1'b0;
         lcd_update_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         wait_cnt_q     <= wait_cnt_d;
         wait_time_q    <= wait_time_d;
         meas_cnt_q     <= meas_cnt_d;
         winner_q       <= winner_d;
         winner_valid_q <= winner_valid_d;
         led_q          <= led_d;
         wait_q         <= wait_d;
         lcd_update_q   <= lcd_update_d;
      end
   end

   assign LED         = led_q;
   assign Winner      = winner_q;
   assign WinnerValid = winner_valid_q;
   assign Wait        = wait_q;
   assign LCDUpdate   = lcd_update_q;

endmodule
`default_nettype wire

// File: tb/tb_reaction_timer_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reaction_timer_multi
//  Description : Self-checking bench for reaction_timer_multi (2 players).
//                Directed round table plus randomized rounds scored by a
//                round-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reaction_timer_multi;

   localparam int NP         = 2;
   localparam int TIME_W     = 10;
   localparam int RAND_W     = 13;
   localparam int LED_W      = 8;
   localparam int SLOW_LIMIT = 1000;
   localparam int MIN_WAIT   = 100;
   localparam int END_WAIT   = 1000;

   typedef struct {
      int       rv;
      int       ack;
      int       pt0;
      int       pt1;
      int       h0;
      int       h1;
      bit       probe;
      int       e_t0;
      int       e_t1;
      bit [1:0] e_cheat;
      bit [1:0] e_slow;
      int       e_win;
      bit       e_valid;
      int       e_rw;
      int       e_meas;
   } vec_t;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [NP-1:0]          start;
   logic [RAND_W-1:0]      rand_v;
   logic                   lcd_ack;
   logic [LED_W-1:0]       led;
   logic [NP*TIME_W-1:0]   reaction_time;
   logic [NP-1:0]          cheat;
   logic [NP-1:0]          slow;
   logic [2:0]             winner;
   logic                   winner_valid;
   logic                   wait_o;
   logic                   lcd_update;

   int n_chk = 0;
   int n_err = 0;
   bit kicked = 0;

   reaction_timer_multi #(
      .NUM_PLAYERS (NP),
      .TIME_W      (TIME_W),
      .RAND_W      (RAND_W),
      .LED_W       (LED_W),
      .SLOW_LIMIT  (SLOW_LIMIT),
      .MIN_WAIT    (MIN_WAIT),
      .END_WAIT    (END_WAIT)
   ) dut (
      .Clk          (clk),
      .Rst          (rst),
      .Start        (start),
      .RandomValue  (rand_v),
      .LCDAck       (lcd_ack),
      .LED          (led),
      .ReactionTime (reaction_time),
      .Cheat        (cheat),
      .Slow         (slow),
      .Winner       (winner),
      .WinnerValid  (winner_valid),
      .Wait         (wait_o),
      .LCDUpdate    (lcd_update)
   );

   always #5 clk = ~clk;

   initial begin
      #950000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 'h%0h, expected 'h%0h", nm, act, exp);
      end
   endtask

   // Round-level reference: derive flags, times and phase lengths from the
   // absolute press cycles (counted from the first random-wait cycle).
   task automatic model(inout vec_t v);
      int w;
      int pt [NP];
      int tm [NP];
      bit dn [NP];
      bit all_ch;
      bit any_slow;
      int mx;
      int best;
      pt[0] = v.pt0;
      pt[1] = v.pt1;
      w = (v.rv < MIN_WAIT) ? MIN_WAIT : v.rv;
      all_ch = 1;
      for (int p = 0; p < NP; p++) all_ch &= (pt[p] >= 0 && pt[p] < w);
      v.e_cheat = '0; v.e_slow = '0; v.e_valid = 0; v.e_win = 0;
      any_slow = 0; mx = -1; best = 0;
      for (int p = 0; p < NP; p++) begin
         dn[p] = 0;
         if (pt[p] >= 0 && pt[p] < w) begin
            v.e_cheat[p] = 1'b1; tm[p] = 0;
         end else if (pt[p] >= 0 && (pt[p] - w) < SLOW_LIMIT) begin
            dn[p] = 1; tm[p] = pt[p] - w;
         end else begin
            v.e_slow[p] = 1'b1; tm[p] = SLOW_LIMIT; any_slow = 1;
         end
      end
      if (all_ch) begin
         for (int p = 0; p < NP; p++) if (pt[p] > mx) mx = pt[p];
         v.e_rw = mx + 1; v.e_meas = 0;
      end else begin
         v.e_rw = w;
         for (int p = 0; p < NP; p++) if (dn[p] && tm[p] > mx) mx = tm[p];
         v.e_meas = any_slow ? SLOW_LIMIT + 1 : mx + 1;
      end
      for (int p = 0; p < NP; p++) begin
         if (dn[p] && (!v.e_valid || tm[p] < best)) begin
            v.e_valid = 1; v.e_win = p; best = tm[p];
         end
      end
      v.e_t0 = tm[0];
      v.e_t1 = tm[1];
   endtask

   // Arm the round (unless already armed), check the cleared results, then
   // acknowledge the wait message. Returns at random-wait cycle 0.
   task automatic kick_and_ack(input int rv, input int ack_dly);
      if (!kicked) begin
         @(negedge clk); start = 2'b01;
         @(negedge clk); start = 2'b00;
      end
      kicked = 0;
      chk("wait_msg_entry", {lcd_update, wait_o, led}, {1'b1, 1'b1, 8'h00});
      chk("round_clear", {reaction_time, cheat, slow, winner_valid}, '0);
      repeat (ack_dly) @(negedge clk);
      chk("wait_msg_hold", {lcd_update, wait_o}, 2'b11);
      rand_v = RAND_W'(rv); lcd_ack = 1'b1;
      @(negedge clk); lcd_ack = 1'b0;
      chk("wait_ack_drop", {lcd_update, wait_o}, 2'b01);
   endtask

   // Drive the presses cycle by cycle until the result message appears.
   task automatic play(input vec_t v, output int rw, output int meas, output bit seq_ok);
      int t = 0;
      rw = 0; meas = 0; seq_ok = 1;
      while (!lcd_update && t < 20000) begin
         if (wait_o && led == '0 && meas == 0) rw++;
         else if (!wait_o && led == '1) meas++;
         else seq_ok = 0;
         start[0] = (v.pt0 >= 0) && (t >= v.pt0) && (t < v.pt0 + v.h0);
         start[1] = (v.pt1 >= 0) && (t >= v.pt1) && (t < v.pt1 + v.h1);
         @(negedge clk);
         t++;
      end
      if (t >= 20000) chk("result_timeout", 1'b1, 1'b0);
   endtask

   // Acknowledge the result, then either probe the END_WAIT boundary (which
   // leaves the next round armed) or idle and confirm the results persist.
   task automatic finish_round(input int ack_dly, input bit probe,
                               input logic [NP*TIME_W-1:0] exp_rt, input bit exp_valid);
      start = '0;
      repeat (ack_dly) @(negedge clk);
      chk("result_lcd_hold", {lcd_update, reaction_time}, {1'b1, exp_rt});
      lcd_ack = 1'b1;
      @(negedge clk); lcd_ack = 1'b0;
      chk("result_ack_drop", lcd_update, 1'b0);
      if (probe) begin
         repeat (END_WAIT - 1) @(negedge clk);
         start = 2'b10;
         @(negedge clk); start = 2'b00;
         chk("end_wait_ignores_press", lcd_update, 1'b0);
         @(negedge clk); start = 2'b10;
         @(negedge clk); start = 2'b00;
         chk("end_wait_to_idle", lcd_update, 1'b1);
         kicked = 1;
      end else begin
         repeat (END_WAIT + 2) @(negedge clk);
         chk("idle_results_held", {lcd_update, reaction_time, winner_valid},
             {1'b0, exp_rt, exp_valid});
      end
   endtask

   task automatic run_one(input vec_t v);
      int rw, meas;
      bit seq_ok;
      logic [NP*TIME_W-1:0] exp_rt;
      exp_rt = {TIME_W'(v.e_t1), TIME_W'(v.e_t0)};
      kick_and_ack(v.rv, v.ack);
      play(v, rw, meas, seq_ok);
      chk("random_wait_cycles", rw, v.e_rw);
      chk("measure_cycles", meas, v.e_meas);
      chk("led_wait_sequence", seq_ok, 1'b1);
      chk("result_led_wait", {led, wait_o}, '0);
      chk("reaction_time", reaction_time, exp_rt);
      chk("cheat", cheat, v.e_cheat);
      chk("slow", slow, v.e_slow);
      chk("winner_valid", winner_valid, v.e_valid);
      if (v.e_valid) chk("winner", winner, v.e_win);
      finish_round(v.ack, v.probe, exp_rt, v.e_valid);
   endtask

   vec_t vecs [7];

   initial begin
      vec_t rv_vec;
      int   w;
      // rv ack pt0 pt1 h0 h1 probe | t0 t1 cheat slow win valid rw meas
      vecs[0] = '{50,  3, 105,  -1, 4,      4, 0,    5, 1000, 2'b00, 2'b10, 0, 1, 100, 1001};
      vecs[1] = '{300, 2, 550, 420, 4,      4, 1,  250,  120, 2'b00, 2'b00, 1, 1, 300,  251};
      vecs[2] = '{300, 1,  10, 340, 100000, 4, 0,    0,   40, 2'b01, 2'b00, 1, 1, 300,   41};
      vecs[3] = '{300, 0,   5,  20, 4,      4, 0,    0,    0, 2'b11, 2'b00, 0, 0,  21,    0};
      vecs[4] = '{120, 1,  -1,  -1, 4,      4, 0, 1000, 1000, 2'b00, 2'b11, 0, 0, 120, 1001};
      vecs[5] = '{100, 2, 1100, 600, 4,     4, 0, 1000,  500, 2'b00, 2'b01, 1, 1, 100, 1001};
      vecs[6] = '{200, 1, 277, 277, 4,      4, 0,   77,   77, 2'b00, 2'b00, 0, 1, 200,   78};

      rst = 1'b1; start = '0; rand_v = '0; lcd_ack = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", {led, reaction_time, cheat, slow, winner, winner_valid, wait_o, lcd_update}, '0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("idle_after_reset", {led, reaction_time, cheat, slow, winner, winner_valid, wait_o, lcd_update}, '0);

      for (int i = 0; i < 7; i++) run_one(vecs[i]);

      // Asynchronous reset in the middle of MEASURE.
      begin
         int guard = 0;
         int m = 0;
         kick_and_ack(150, 1);
         while (led != '1 && guard < 1000) begin @(negedge clk); guard++; end
         chk("measure_reached", led, 8'hFF);
         while (m < 3) begin @(negedge clk); m++; end
         start = 2'b01;
         @(negedge clk); start = 2'b00;
         repeat (5) @(negedge clk);
         chk("pre_reset_time", {reaction_time, led}, {TIME_W'(0), TIME_W'(3), 8'hFF});
         #2 rst = 1'b1;
         #1 chk("async_reset_clears", {led, reaction_time, cheat, slow, winner, winner_valid, wait_o, lcd_update}, '0);
         @(negedge clk); rst = 1'b0;
         repeat (5) @(negedge clk);
         chk("post_reset_idle", {lcd_update, wait_o, led}, '0);
      end

      for (int r = 0; r < 10; r++) begin
         rv_vec.rv    = $urandom_range(0, 400);
         rv_vec.ack   = $urandom_range(0, 4);
         rv_vec.h0    = $urandom_range(1, 6);
         rv_vec.h1    = $urandom_range(1, 6);
         rv_vec.probe = 0;
         w = (rv_vec.rv < MIN_WAIT) ? MIN_WAIT : rv_vec.rv;
         rv_vec.pt0 = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, w + 1100));
         rv_vec.pt1 = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, w + 1100));
         model(rv_vec);
         run_one(rv_vec);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
